// File: rtl/coin_acceptor.sv
// Coin qualifier: synchronises and debounces the raw coin switches, then emits one
// 2-bit coin code per insertion on a valid/ready handshake, or a reject pulse.
module coin_acceptor #(
   parameter int STABLE_CYCLES = 16
) (
   input  logic       clock_50MHz,
   input  logic       async_Reset,
   input  logic [2:0] coin,
   input  logic       coin_ready,
   output logic       coin_valid,
   output logic [1:0] coin_code,
   output logic       coin_reject,
   output logic       busy,
   output logic [7:0] coin_count
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      QUALIFY      = 2'd1,
      PENDING      = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [2:0]    r_sync1, r_s;
   logic [2:0]    r_cand, w_cand_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]    r_code, w_code_nxt;
   logic          r_reject, w_reject_nxt;
   logic [7:0]    r_count, w_count_nxt;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others; blocking here would create ordering races.
   always_ff @(posedge clock_50MHz or negedge async_Reset) begin
      if (!async_Reset) begin
         r_sync1  <= 3'b000;
         r_s      <= 3'b000;
         r_state  <= IDLE;
         r_cand   <= 3'b000;
         r_cnt    <= '0;
         r_code   <= 2'b00;
         r_reject <= 1'b0;
         r_count  <= 8'd0;
      end else begin
         r_sync1  <= coin;
         r_s      <= r_sync1;
         r_state  <= w_state_nxt;
         r_cand   <= w_cand_nxt;
         r_cnt    <= w_cnt_nxt;
         r_code   <= w_code_nxt;
         r_reject <= w_reject_nxt;
         r_count  <= w_count_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_cand_nxt   = r_cand;
      w_cnt_nxt    = r_cnt;
      w_code_nxt   = r_code;
      w_reject_nxt = 1'b0;
      w_count_nxt  = r_count;
      case (r_state)
         IDLE: begin
            if (r_s != 3'b000) begin
               w_state_nxt = QUALIFY;
               w_cand_nxt  = r_s;
               w_cnt_nxt   = CW'(1);
            end
         end
         QUALIFY: begin
            if (r_s == 3'b000) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_s != r_cand) begin
               w_cand_nxt = r_s;
               w_cnt_nxt  = CW'(1);
            end else if (r_cnt < LAST) begin
               w_cnt_nxt = r_cnt + CW'(1);
            end else begin
               w_cnt_nxt = '0;
               if ($onehot(r_cand)) begin
                  w_state_nxt = PENDING;
                  // 001 -> 01, 010 -> 10, 100 -> 11
                  w_code_nxt  = {r_cand[2] | r_cand[1], r_cand[2] | r_cand[0]};
               end else begin
                  w_state_nxt  = WAIT_RELEASE;
                  w_reject_nxt = 1'b1;
               end
            end
         end
         PENDING: begin
            if (coin_ready) begin
               w_state_nxt = WAIT_RELEASE;
               w_cnt_nxt   = '0;
               w_code_nxt  = 2'b00;
               if (r_count != 8'hFF) begin
                  w_count_nxt = r_count + 8'd1;
               end
            end
         end
         WAIT_RELEASE: begin
            // A still-held coin keeps resetting the release window.
            if (r_s != 3'b000) begin
               w_cnt_nxt = '0;
            end else if (r_cnt >= LAST) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_code_nxt  = 2'b00;
         end
      endcase
   end

   assign coin_valid  = (r_state == PENDING);
   assign coin_code   = r_code;
   assign coin_reject = r_reject;
   assign busy        = (r_state != IDLE);
   assign coin_count  = r_count;

endmodule
